// File: rtl/ex_stage_if.sv
// Interface bundle for the execute stage. It carries the ID/EX pipeline
// inputs, the hazard-unit forwarding selects and writeback value, the
// registered EX/MEM outputs, and the combinational branch-resolution outputs.
interface ex_stage_if;
  logic [31:0] rd1E;
  logic [31:0] rd2E;
  logic [31:0] pcE;
  logic [31:0] PCPlus4E;
  logic [31:0] extImmE;
  logic [31:0] rdE;
  logic        regWriteE;
  logic        memWriteE;
  logic        jumpE;
  logic        branchE;
  logic        ALUsrcE;
  logic [3:0]  ALUcontrolE;
  logic [1:0]  ResultSrcE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;

  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] rdM;
  logic [31:0] PCPlus4M;
  logic        regWriteM;
  logic        memWriteM;
  logic [1:0]  ResultSrcM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        ZeroE;

  // Execute stage side: consumes E-stage values, produces M-stage values.
  modport slave (
    input  rd1E, rd2E, pcE, PCPlus4E, extImmE, rdE,
           regWriteE, memWriteE, jumpE, branchE, ALUsrcE,
           ALUcontrolE, ResultSrcE, ForwardAE, ForwardBE, ResultW,
    output ALUResultM, WriteDataM, rdM, PCPlus4M, regWriteM, memWriteM,
           ResultSrcM, PCSrcE, PCTargetE, ZeroE
  );

  // Pipeline/driver side: produces E-stage values, observes results.
  modport master (
    output rd1E, rd2E, pcE, PCPlus4E, extImmE, rdE,
           regWriteE, memWriteE, jumpE, branchE, ALUsrcE,
           ALUcontrolE, ResultSrcE, ForwardAE, ForwardBE, ResultW,
    input  ALUResultM, WriteDataM, rdM, PCPlus4M, regWriteM, memWriteM,
           ResultSrcM, PCSrcE, PCTargetE, ZeroE
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the five-stage RV32I pipeline: operand forwarding, ALU,
// BEQ/JAL-style branch resolution and the EX/MEM pipeline register.
module ex_stage (
  input  logic        CLK,
  input  logic        reset,
  ex_stage_if.slave   bus
);

  logic [31:0] src_a_s;
  logic [31:0] fwd_b_s;
  logic [31:0] src_b_s;
  logic [31:0] alu_s;

  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] rd_q,         rd_d;
  logic [31:0] pc_plus4_q,   pc_plus4_d;
  logic        reg_write_q,  reg_write_d;
  logic        mem_write_q,  mem_write_d;
  logic [1:0]  result_src_q, result_src_d;

  // Forwarding muxes; MEM forwarding uses the registered result so no loop forms.
  always_comb begin
    src_a_s = bus.rd1E;
    fwd_b_s = bus.rd2E;
    case (bus.ForwardAE)
      2'b01:   src_a_s = bus.ResultW;
      2'b10:   src_a_s = alu_result_q;
      default: src_a_s = bus.rd1E;
    endcase
    case (bus.ForwardBE)
      2'b01:   fwd_b_s = bus.ResultW;
      2'b10:   fwd_b_s = alu_result_q;
      default: fwd_b_s = bus.rd2E;
    endcase
    if (bus.ALUsrcE) begin
      src_b_s = bus.extImmE;
    end else begin
      src_b_s = fwd_b_s;
    end
  end

  // ALU; unused encodings yield zero and overflow is ignored.
  always_comb begin
    alu_s = 32'd0;
    case (bus.ALUcontrolE)
      4'b0000: alu_s = src_a_s + src_b_s;
      4'b0001: alu_s = src_a_s - src_b_s;
      4'b0010: alu_s = src_a_s & src_b_s;
      4'b0011: alu_s = src_a_s | src_b_s;
      4'b0100: alu_s = src_a_s ^ src_b_s;
      4'b0101: alu_s = {31'd0, ($signed(src_a_s) < $signed(src_b_s))};
      4'b0110: alu_s = {31'd0, (src_a_s < src_b_s)};
      4'b0111: alu_s = src_a_s << src_b_s[4:0];
      4'b1000: alu_s = src_a_s >> src_b_s[4:0];
      4'b1001: alu_s = $signed(src_a_s) >>> src_b_s[4:0];
      default: alu_s = 32'd0;
    endcase
  end

  // Branch resolution: only compare-equal branches, with the ALU subtracting.
  assign bus.ZeroE     = (alu_s == 32'd0);
  assign bus.PCSrcE    = bus.jumpE | (bus.branchE & bus.ZeroE);
  assign bus.PCTargetE = bus.pcE + bus.extImmE;

  // Next-state values for the EX/MEM register; the stage always advances.
  always_comb begin
    alu_result_d = alu_s;
    write_data_d = fwd_b_s;
    rd_d         = bus.rdE;
    pc_plus4_d   = bus.PCPlus4E;
    reg_write_d  = bus.regWriteE;
    mem_write_d  = bus.memWriteE;
    result_src_d = bus.ResultSrcE;
  end

  // EX/MEM pipeline register, cleared asynchronously while reset is low.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      alu_result_q <= 32'd0;
      write_data_q <= 32'd0;
      rd_q         <= 32'd0;
      pc_plus4_q   <= 32'd0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
    end
  end

  assign bus.ALUResultM = alu_result_q;
  assign bus.WriteDataM = write_data_q;
  assign bus.rdM        = rd_q;
  assign bus.PCPlus4M   = pc_plus4_q;
  assign bus.regWriteM  = reg_write_q;
  assign bus.memWriteM  = mem_write_q;
  assign bus.ResultSrcM = result_src_q;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32I pipeline: the consumer of the decode-to-execute pipeline register outputs (the `*E` signals). It applies hazard-unit forwarding and runs the ALU. It resolves branches and jumps back toward fetch. It registers its results into the execute-to-memory pipeline register (the `*M` signals) on each rising clock edge.

## Interface
No parameters; data width is fixed at 32.
- CLK  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all registered outputs immediately
- rd1E, rd2E  in  32  register-file read data from ID/EX
- pcE, PCPlus4E, extImmE  in  32  PC, PC+4, extended immediate
- rdE  in  32  destination register index (low 5 bits significant, carried in full)
- regWriteE, memWriteE, jumpE, branchE, ALUsrcE  in  1  control bits
- ALUcontrolE  in  4  ALU operation
- ResultSrcE  in  2  writeback select, passed through
- ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit
- ResultW  in  32  writeback-stage result
- ALUResultM  out  32  registered ALU result; also the forwarding source for select 10
- WriteDataM  out  32  registered store data
- rdM, PCPlus4M  out  32  registered destination register and PC+4
- regWriteM, memWriteM  out  1  registered control
- ResultSrcM  out  2  registered writeback select
- PCSrcE  out  1  combinational; 1 means fetch must redirect to PCTargetE
- PCTargetE  out  32  combinational pcE + extImmE
- ZeroE  out  1  combinational; 1 when the ALU result equals 0

## Operation
- Operand A is selected by ForwardAE: 00 gives rd1E, 01 gives ResultW, 10 gives ALUResultM, and 11 is treated as 00.
- The forwarded B value uses ForwardBE with the same encoding applied to rd2E.
- WriteDataE is the forwarded B value.
- Operand B is extImmE when ALUsrcE = 1; otherwise it is the forwarded B value.
- ALUcontrolE encoding (all arithmetic is mod 2^32):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT (signed, result 1 or 0), 0110 SLTU (unsigned)
  - 0111 SLL, 1000 SRL, 1001 SRA; the shift amount is B[4:0]
  - Any other encoding produces 0.
- Branch and jump resolution:
  - PCSrcE = jumpE | (branchE & ZeroE). Only BEQ-style compare-equal branches are supported, with the ALU doing SUB.
  - PCTargetE is always pcE + extImmE. JALR target selection is out of scope for this block.
- The hazard unit consumes PCSrcE to flush the ID/EX and IF/ID registers.

## Timing
- Combinational path: operands to ALU result to ZeroE, PCSrcE and PCTargetE within the same cycle as the E inputs.
- Registered path, one cycle latency. On each rising CLK edge with reset = 1:
  - ALUResultM gets the ALU result; WriteDataM gets WriteDataE.
  - rdM, PCPlus4M, regWriteM, memWriteM and ResultSrcM get their E counterparts.
- There is no stall or flush input. Execute-to-memory always advances. Bubbles arrive as zeroed E inputs from a flushed ID/EX, so they produce regWriteM = memWriteM = 0.
- Reset (reset = 0, any time, independent of CLK): every M output goes to 0 immediately and holds 0 while reset is low.
  - The first capture is the first rising edge after reset deasserts.
  - Combinational outputs keep tracking their inputs during reset.
- Forwarding from ALUResultM uses the registered value, i.e. the previous instruction's result, with no combinational loop.
- Overflow is ignored. SUB with equal operands gives ZeroE = 1, including 0x80000000 − 0x80000000.

## Test plan
- **ADD with MEM forward:** ALUResultM = 5 (prior cycle), ForwardAE = 10, rd2E = 7, ALUcontrolE = 0000 -> ALUResultM = 12 on the next edge.
- **Immediate and shift:** ALUsrcE = 1, extImmE = 4, rd1E = 0x80000000, ForwardAE = 00, SRA -> ALUResultM = 0xF8000000. The same inputs with SRL -> 0x08000000.
- **Signed vs unsigned compare:** rd1E = 0xFFFFFFFF, rd2E = 1 -> SLT gives 1, SLTU gives 0.
- **Branch resolution:**
  - branchE = 1, SUB, rd1E = rd2E = 9, pcE = 0x100, extImmE = 0x20 -> PCSrcE = 1, PCTargetE = 0x120 in the same cycle.
  - rd2E = 8 -> PCSrcE = 0.
  - jumpE = 1 with any operands -> PCSrcE = 1.
- **Writeback forward and store data:** ForwardBE = 01, ResultW = 0xDEADBEEF, memWriteE = 1, ALUsrcE = 1 -> WriteDataM = 0xDEADBEEF, memWriteM = 1.
- **Async reset mid-stream:** with nonzero M outputs, drop reset between edges -> all M outputs read 0 before the next edge and stay 0 until the first edge after reset rises.
